// File: rtl/aes_frame_pkg.sv
// Shared types and constants for the UART-to-AES frame controller.
package aes_frame_pkg;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BLOCK_W     = BLOCK_BYTES * 8;
    localparam int unsigned CNT_W       = $clog2(BLOCK_BYTES);

    localparam logic [7:0] CMD_KEY  = 8'h4B;
    localparam logic [7:0] CMD_ENC  = 8'h45;
    localparam logic [7:0] CMD_STAT = 8'h53;

    // Sticky error vector bit positions; the status byte is {3'b000, key_valid, err}
    localparam int unsigned ERR_CMD   = 0;
    localparam int unsigned ERR_TMO   = 1;
    localparam int unsigned ERR_NOKEY = 2;
    localparam int unsigned ERR_OVR   = 3;
    localparam int unsigned ERR_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        ISSUE,
        WAIT_CORE,
        RESP
    } state_t;

endpackage

// File: rtl/aes_frame_shreg.sv
// Block assembly shift register shared by key and plaintext frames.
// Holds 15 bytes; the 16th is merged combinationally so the block is usable on arrival.
module aes_frame_shreg
    import aes_frame_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic [BLOCK_W-1:0] blk_c,
    output logic               full_c
);

    logic [BLOCK_W-9:0] data;
    logic [CNT_W-1:0]   cnt;

    assign blk_c  = {data, byte_in};
    assign full_c = shift_en && (cnt == CNT_W'(BLOCK_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            data <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            data <= {data[BLOCK_W-17:0], byte_in};
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/aes_frame_ctrl.sv
// Frame parser and AES core sequencer with sticky protocol status.
// Define AES_FRAME_TIMEOUT_EN to enable the inter-byte timeout (TIMEOUT_CYC).
module aes_frame_ctrl
    import aes_frame_pkg::*;
`ifdef AES_FRAME_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
)
`endif
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_dv_in,
    input  logic [7:0]         rx_byte_in,
    output logic [BLOCK_W-1:0] core_key_out,
    output logic               core_key_load_out,
    output logic [BLOCK_W-1:0] core_pt_out,
    output logic               core_start_out,
    input  logic               core_done_in,
    input  logic [BLOCK_W-1:0] core_ct_in,
    output logic               resp_valid_out,
    output logic [BLOCK_W-1:0] resp_data_out,
    output logic               resp_is_stat_out,
    input  logic               resp_ready_in,
    output logic               busy_out
);

    state_t             state, state_nxt;
    logic               is_key, is_key_nxt;
    logic               key_valid, key_valid_nxt;
    logic [ERR_W-1:0]   err, err_nxt;
    logic [BLOCK_W-1:0] core_key_nxt, core_pt_nxt, resp_data_nxt;
    logic               core_key_load_nxt, core_start_nxt;
    logic               resp_valid_nxt, resp_is_stat_nxt, busy_nxt;
    logic               sh_clr, sh_shift, sh_full_c;
    logic [BLOCK_W-1:0] sh_blk_c;
    logic [7:0]         status_c;
    logic               tmo_hit_c;

    assign status_c = {3'b000, key_valid, err};

    aes_frame_shreg u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clr      (sh_clr),
        .shift_en (sh_shift),
        .byte_in  (rx_byte_in),
        .blk_c    (sh_blk_c),
        .full_c   (sh_full_c)
    );

`ifdef AES_FRAME_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit_c = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Idle cycles since the last payload byte; only runs while collecting payload
    always_ff @(posedge clk) begin
        if (rst || (state != PAYLOAD) || rx_dv_in) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_hit_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            is_key            <= 1'b0;
            key_valid         <= 1'b0;
            err               <= '0;
            core_key_out      <= '0;
            core_key_load_out <= 1'b0;
            core_pt_out       <= '0;
            core_start_out    <= 1'b0;
            resp_valid_out    <= 1'b0;
            resp_data_out     <= '0;
            resp_is_stat_out  <= 1'b0;
            busy_out          <= 1'b0;
        end else begin
            state             <= state_nxt;
            is_key            <= is_key_nxt;
            key_valid         <= key_valid_nxt;
            err               <= err_nxt;
            core_key_out      <= core_key_nxt;
            core_key_load_out <= core_key_load_nxt;
            core_pt_out       <= core_pt_nxt;
            core_start_out    <= core_start_nxt;
            resp_valid_out    <= resp_valid_nxt;
            resp_data_out     <= resp_data_nxt;
            resp_is_stat_out  <= resp_is_stat_nxt;
            busy_out          <= busy_nxt;
        end
    end

    // Core pulses are launched on entry to ISSUE so they appear one cycle after the last byte
    always_comb begin
        state_nxt         = state;
        is_key_nxt        = is_key;
        key_valid_nxt     = key_valid;
        err_nxt           = err;
        core_key_nxt      = core_key_out;
        core_key_load_nxt = 1'b0;
        core_pt_nxt       = core_pt_out;
        core_start_nxt    = 1'b0;
        resp_valid_nxt    = resp_valid_out;
        resp_data_nxt     = resp_data_out;
        resp_is_stat_nxt  = resp_is_stat_out;
        sh_clr            = 1'b0;
        sh_shift          = 1'b0;

        case (state)
            IDLE: begin
                if (rx_dv_in) begin
                    if ((rx_byte_in == CMD_KEY) || (rx_byte_in == CMD_ENC)) begin
                        is_key_nxt = (rx_byte_in == CMD_KEY);
                        sh_clr     = 1'b1;
                        state_nxt  = PAYLOAD;
                    end else if (rx_byte_in == CMD_STAT) begin
                        resp_valid_nxt   = 1'b1;
                        resp_data_nxt    = BLOCK_W'(status_c);
                        resp_is_stat_nxt = 1'b1;
                        state_nxt        = RESP;
                    end else begin
                        err_nxt[ERR_CMD] = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_dv_in) begin
                    sh_shift = 1'b1;
                    if (sh_full_c) begin
                        state_nxt = ISSUE;
                        if (is_key) begin
                            core_key_nxt      = sh_blk_c;
                            core_key_load_nxt = 1'b1;
                            key_valid_nxt     = 1'b1;
                        end else if (key_valid) begin
                            core_pt_nxt    = sh_blk_c;
                            core_start_nxt = 1'b1;
                        end
                    end
                end else if (tmo_hit_c) begin
                    err_nxt[ERR_TMO] = 1'b1;
                    sh_clr           = 1'b1;
                    state_nxt        = IDLE;
                end
            end
            ISSUE: begin
                if (!is_key && !key_valid) begin
                    err_nxt[ERR_NOKEY] = 1'b1;
                end
                state_nxt = (!is_key && key_valid) ? WAIT_CORE : IDLE;
            end
            WAIT_CORE: begin
                if (rx_dv_in) begin
                    err_nxt[ERR_OVR] = 1'b1;
                end
                if (core_done_in) begin
                    resp_valid_nxt   = 1'b1;
                    resp_data_nxt    = core_ct_in;
                    resp_is_stat_nxt = 1'b0;
                    state_nxt        = RESP;
                end
            end
            RESP: begin
                if (resp_ready_in) begin
                    if (resp_is_stat_out) begin
                        err_nxt = '0;
                    end
                    resp_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
                if (rx_dv_in) begin
                    err_nxt[ERR_OVR] = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_aes_frame_ctrl.sv
// Scoreboard bench for aes_frame_ctrl: randomized frames against a protocol-level model.
// Build with AES_FRAME_TIMEOUT_EN to exercise the inter-byte timeout.
`timescale 1ns/1ps
module tb_aes_frame_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] FIPS_PT  = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841D02DC09FBDC118597196A0B32;

    typedef struct packed {
        logic         is_stat;
        logic [127:0] data;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_dv_in;
    logic [7:0]   rx_byte_in;
    logic [127:0] core_key_out;
    logic         core_key_load_out;
    logic [127:0] core_pt_out;
    logic         core_start_out;
    logic         core_done_in;
    logic [127:0] core_ct_in;
    logic         resp_valid_out;
    logic [127:0] resp_data_out;
    logic         resp_is_stat_out;
    logic         resp_ready_in;
    logic         busy_out;

    always #5 clk = ~clk;

`ifdef AES_FRAME_TIMEOUT_EN
    aes_frame_ctrl #(.TIMEOUT_CYC(100)) dut (
        .clk               (clk),
        .rst               (rst),
        .rx_dv_in          (rx_dv_in),
        .rx_byte_in        (rx_byte_in),
        .core_key_out      (core_key_out),
        .core_key_load_out (core_key_load_out),
        .core_pt_out       (core_pt_out),
        .core_start_out    (core_start_out),
        .core_done_in      (core_done_in),
        .core_ct_in        (core_ct_in),
        .resp_valid_out    (resp_valid_out),
        .resp_data_out     (resp_data_out),
        .resp_is_stat_out  (resp_is_stat_out),
        .resp_ready_in     (resp_ready_in),
        .busy_out          (busy_out)
    );
`else
    aes_frame_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .rx_dv_in          (rx_dv_in),
        .rx_byte_in        (rx_byte_in),
        .core_key_out      (core_key_out),
        .core_key_load_out (core_key_load_out),
        .core_pt_out       (core_pt_out),
        .core_start_out    (core_start_out),
        .core_done_in      (core_done_in),
        .core_ct_in        (core_ct_in),
        .resp_valid_out    (resp_valid_out),
        .resp_data_out     (resp_data_out),
        .resp_is_stat_out  (resp_is_stat_out),
        .resp_ready_in     (resp_ready_in),
        .busy_out          (busy_out)
    );
`endif

    int           n_chk = 0;
    int           n_fail = 0;
    int           n_keyload = 0;
    logic [127:0] exp_key_q[$];
    logic [127:0] exp_pt_q[$];
    resp_t        exp_resp_q[$];

    // Protocol-level model state
    bit           m_kv;
    logic [3:0]   m_err;   // {ovr, nokey, tmo, cmd}
    logic [127:0] m_key;

    bit           core_auto = 1'b1;
    bit           rand_ready = 1'b1;
    bit           hold_pending = 1'b0;
    logic [127:0] held_data;
    logic [127:0] mon_exp;
    resp_t        mon_resp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Stand-in cipher: known-answer pair for the reference vector, otherwise a keyed scramble
    function automatic logic [127:0] fake_ct(input logic [127:0] k, input logic [127:0] pt);
        if (k == FIPS_KEY && pt == FIPS_PT) return FIPS_CT;
        return {pt[63:0], pt[127:64]} ^ k ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a pulse or a response handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (core_key_load_out) begin
                n_keyload++;
                if (exp_key_q.size() == 0) fail_now("keyload_unexpected");
                else begin
                    mon_exp = exp_key_q.pop_front();
                    check("core_key", core_key_out, mon_exp);
                end
            end
            if (core_start_out) begin
                if (exp_pt_q.size() == 0) fail_now("start_unexpected");
                else begin
                    mon_exp = exp_pt_q.pop_front();
                    check("core_pt", core_pt_out, mon_exp);
                end
            end
            if (resp_valid_out) begin
                if (hold_pending) check("resp_hold", resp_data_out, held_data);
                if (resp_ready_in) begin
                    hold_pending = 1'b0;
                    if (exp_resp_q.size() == 0) fail_now("resp_unexpected");
                    else begin
                        mon_resp = exp_resp_q.pop_front();
                        check("resp_data", resp_data_out, mon_resp.data);
                        check("resp_is_stat", 128'(resp_is_stat_out), 128'(mon_resp.is_stat));
                    end
                end else begin
                    hold_pending = 1'b1;
                    held_data    = resp_data_out;
                end
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    // Core model: answers each start after a random delay
    always begin
        @(negedge clk);
        if (core_start_out && core_auto && !rst) begin
            logic [127:0] ct;
            ct = fake_ct(core_key_out, core_pt_out);
            repeat ($urandom_range(5, 12)) @(posedge clk);
            #1;
            core_done_in = 1'b1;
            core_ct_in   = ct;
            @(posedge clk);
            #1;
            core_done_in = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) resp_ready_in = ($urandom_range(0, 2) != 0);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte_in = b;
        rx_dv_in   = 1'b1;
        @(posedge clk);
        #1;
        rx_dv_in   = 1'b0;
    endtask

    task automatic send_payload(input logic [127:0] blk);
        for (int i = 0; i < 16; i++) begin
            send_byte(blk[127 - 8*i -: 8]);
            if (i < 15) idle($urandom_range(0, 2));
        end
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!busy_out) done = 1'b1;
        end
        if (!done) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic do_key(input logic [127:0] k);
        send_byte(8'h4B);
        exp_key_q.push_back(k);
        send_payload(k);
        m_kv  = 1'b1;
        m_key = k;
        @(negedge clk);
        check("keyload_latency", 128'(core_key_load_out), 128'(1));
        @(posedge clk);
        #1;
        wait_idle("key_idle");
    endtask

    task automatic do_enc(input logic [127:0] pt, input bit stray);
        bit    kv = m_kv;
        resp_t r;
        send_byte(8'h45);
        if (kv) begin
            r.is_stat = 1'b0;
            r.data    = fake_ct(m_key, pt);
            exp_pt_q.push_back(pt);
            exp_resp_q.push_back(r);
        end else begin
            m_err[2] = 1'b1;
        end
        send_payload(pt);
        @(negedge clk);
        check("start_latency", 128'(core_start_out), 128'(kv));
        @(posedge clk);
        #1;
        if (stray && kv) begin
            @(posedge clk);
            #1;
            send_byte(8'($urandom));
            m_err[3] = 1'b1;
        end
        wait_idle("enc_idle");
    endtask

    task automatic do_stat(input logic [7:0] exp_stat);
        resp_t r;
        send_byte(8'h53);
        r.is_stat = 1'b1;
        r.data    = 128'(exp_stat);
        exp_resp_q.push_back(r);
        m_err = '0;
        @(negedge clk);
        check("stat_latency", 128'(resp_valid_out), 128'(1));
        @(posedge clk);
        #1;
        wait_idle("stat_idle");
    endtask

    task automatic do_bad(input logic [7:0] b);
        send_byte(b);
        m_err[0] = 1'b1;
        @(negedge clk);
        check("bad_cmd_stays_idle", 128'(busy_out), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int           kl_before;
        bit           seen;
        logic [127:0] k;
        logic [7:0]   b;

        rst = 1'b1; rx_dv_in = 1'b0; rx_byte_in = '0;
        core_done_in = 1'b0; core_ct_in = '0; resp_ready_in = 1'b0;
        m_kv = 1'b0; m_err = '0; m_key = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 128'(resp_valid_out), 128'(0));
        check("rst_busy", 128'(busy_out), 128'(0));
        check("rst_key_load", 128'(core_key_load_out), 128'(0));
        check("rst_start", 128'(core_start_out), 128'(0));
        check("rst_core_key", core_key_out, 128'(0));
        check("rst_core_pt", core_pt_out, 128'(0));
        check("rst_resp_data", resp_data_out, 128'(0));
        check("rst_is_stat", 128'(resp_is_stat_out), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_enc(FIPS_PT, 1'b0);
        do_stat(8'h04);
        do_stat(8'h00);
        do_bad(8'h7A);
        do_stat(8'h01);
        do_stat(8'h00);

        kl_before = n_keyload;
        do_key(FIPS_KEY);
        check("keyload_count", 128'(n_keyload - kl_before), 128'(1));
        check("fips_key", core_key_out, FIPS_KEY);

        // Reference encrypt with the response held under back-pressure
        rand_ready = 1'b0;
        resp_ready_in = 1'b0;
        begin
            resp_t r;
            r.is_stat = 1'b0;
            r.data    = FIPS_CT;
            send_byte(8'h45);
            exp_pt_q.push_back(FIPS_PT);
            exp_resp_q.push_back(r);
        end
        send_payload(FIPS_PT);
        @(negedge clk);
        check("fips_start_latency", 128'(core_start_out), 128'(1));
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid_out) seen = 1'b1;
        end
        if (!seen) fail_now("fips_resp_wait");
        check("fips_ct", resp_data_out, FIPS_CT);
        repeat (5) begin
            @(negedge clk);
            check("fips_hold_valid", 128'(resp_valid_out), 128'(1));
        end
        @(posedge clk);
        #1;
        resp_ready_in = 1'b1;
        @(posedge clk);
        #1;
        rand_ready = 1'b1;
        wait_idle("fips_idle");

        do_enc({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        do_stat(8'h18);

        k = {$urandom, $urandom, $urandom, $urandom};
        send_byte(8'h4B);
        for (int i = 0; i < 5; i++) send_byte(k[127 - 8*i -: 8]);
`ifdef AES_FRAME_TIMEOUT_EN
        idle(99);
        @(negedge clk);
        check("tmo_not_yet", 128'(busy_out), 128'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("tmo_aborted", 128'(busy_out), 128'(0));
        check("tmo_key_kept", core_key_out, m_key);
        @(posedge clk);
        #1;
        m_err[1] = 1'b1;
        do_stat(8'h12);
`else
        idle(150);
        @(negedge clk);
        check("stall_still_busy", 128'(busy_out), 128'(1));
        @(posedge clk);
        #1;
        exp_key_q.push_back(k);
        for (int i = 5; i < 16; i++) send_byte(k[127 - 8*i -: 8]);
        m_kv  = 1'b1;
        m_key = k;
        wait_idle("stall_key_idle");
        check("stall_key", core_key_out, k);
        do_stat(8'h10);
`endif

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: do_key({$urandom, $urandom, $urandom, $urandom});
                1: do_enc({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3) == 0);
                2: do_stat({3'b000, m_kv, m_err});
                default: begin
                    b = 8'($urandom);
                    if (b == 8'h4B || b == 8'h45 || b == 8'h53) b = 8'h00;
                    do_bad(b);
                end
            endcase
        end
        do_stat({3'b000, m_kv, m_err});

        // Reset while the core is busy; its late completion must be ignored
        do_key({$urandom, $urandom, $urandom, $urandom});
        core_auto = 1'b0;
        k = {$urandom, $urandom, $urandom, $urandom};
        send_byte(8'h45);
        exp_pt_q.push_back(k);
        send_payload(k);
        idle(4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_kv = 1'b0;
        m_err = '0;
        core_ct_in   = {$urandom, $urandom, $urandom, $urandom};
        core_done_in = 1'b1;
        @(posedge clk);
        #1;
        core_done_in = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_core_resp_valid", 128'(resp_valid_out), 128'(0));
            check("rst_core_busy", 128'(busy_out), 128'(0));
        end
        check("rst_core_key_out", core_key_out, 128'(0));
        check("rst_core_pt_out", core_pt_out, 128'(0));
        check("rst_core_resp_data", resp_data_out, 128'(0));
        @(posedge clk);
        #1;
        core_auto = 1'b1;
        do_stat(8'h00);

        idle(5);
        check("key_q_empty", 128'(exp_key_q.size()), 128'(0));
        check("pt_q_empty", 128'(exp_pt_q.size()), 128'(0));
        check("resp_q_empty", 128'(exp_resp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
